// File: rtl/hazard_if.sv
// Hazard controller bundle: ID/EX hazard inputs, multi-cycle unit handshake,
// and the stage enable / flush / bubble outputs.
interface hazard_if #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_rs_used;
    logic              id_rt_used;
    logic              id_is_mul;
    logic              ex_valid;
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_wrt_dst;
    logic              ex_branch_taken;
    logic              mul_ready;
    logic              mul_done;
    logic              stat_clr;
    logic              pc_en;
    logic              if_id_en;
    logic              id_ex_en;
    logic              if_id_flush;
    logic              id_ex_bubble;
    logic              ex_mem_bubble;
    logic              mul_start;
    logic              busy;
    logic [CNT_W-1:0]  stall_cnt;

    // Pipeline side drives hazard sources, reads enables.
    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_is_mul,
               ex_valid, ex_mem_read, ex_wrt_dst, ex_branch_taken,
               mul_ready, mul_done, stat_clr,
        input  pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_bubble,
               ex_mem_bubble, mul_start, busy, stall_cnt
    );

    // Controller side.
    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_is_mul,
               ex_valid, ex_mem_read, ex_wrt_dst, ex_branch_taken,
               mul_ready, mul_done, stat_clr,
        output pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_bubble,
               ex_mem_bubble, mul_start, busy, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline interlock controller: load-use stalls, taken-branch flushes,
// multi-cycle unit issue/wait, plus a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int REG_AW   = 4,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic    clk,
    input  logic    rst_n,
    hazard_if.slave hif
);
    typedef enum logic [1:0] {RUN, LOAD_STALL, MUL_WAIT} state_e;

    // Remaining stall cycles loaded on entry to LOAD_STALL (first cycle spent in RUN).
    localparam logic [1:0]       LD_INIT = 2'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [1:0]       ld_cnt_q, ld_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic              load_use;
    logic [REG_AW-1:0] dst;
    logic pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_bubble, ex_mem_bubble, mul_start;

    assign dst = hif.ex_wrt_dst;

    // Load in EX writes a register the ID instruction reads; x0 never hazards.
    always_comb begin
        load_use = hif.id_valid & hif.ex_valid & hif.ex_mem_read & (dst != '0) &
                   ((hif.id_rs_used & (hif.id_rs == dst)) |
                    (hif.id_rt_used & (hif.id_rt == dst)));
    end

    // Next state and stage controls; everything combinational from state + inputs.
    always_comb begin
        state_d       = state_q;
        ld_cnt_d      = ld_cnt_q;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        mul_start     = 1'b0;
        unique case (state_q)
            RUN: begin
                if (hif.ex_branch_taken) begin
                    // ID holds a wrong-path instruction, so this beats any ID hazard.
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (load_use) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_bubble = 1'b1;
                    if (LOAD_LAT > 1) begin
                        ld_cnt_d = LD_INIT;
                        state_d  = LOAD_STALL;
                    end
                end else if (hif.id_valid && hif.id_is_mul && hif.mul_ready) begin
                    mul_start = 1'b1;
                    state_d   = MUL_WAIT;
                end else if (hif.id_valid && hif.id_is_mul) begin
                    // Structural stall until the unit can accept the op.
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            end
            LOAD_STALL: begin
                // EX holds a bubble here, so a branch indication cannot be real.
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_bubble = 1'b1;
                ld_cnt_d     = ld_cnt_q - 2'd1;
                if (ld_cnt_q == 2'd1) state_d = RUN;
            end
            MUL_WAIT: begin
                if (hif.mul_done) begin
                    // Result moves to MEM; no back-to-back issue this cycle.
                    state_d = RUN;
                end else begin
                    pc_en         = 1'b0;
                    if_id_en      = 1'b0;
                    id_ex_en      = 1'b0;
                    ex_mem_bubble = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
        // Hold the whole pipe frozen with a bubble into ID/EX while in reset.
        if (!rst_n) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            if_id_flush   = 1'b0;
            id_ex_bubble  = 1'b1;
            ex_mem_bubble = 1'b0;
            mul_start     = 1'b0;
        end
    end

    // Stall counter: clear beats increment, saturates at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hif.stat_clr)                         stall_cnt_d = '0;
        else if (!pc_en && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // State, load-stall down-counter and stall counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            ld_cnt_q    <= 2'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ld_cnt_q    <= ld_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hif.pc_en         = pc_en;
    assign hif.if_id_en      = if_id_en;
    assign hif.id_ex_en      = id_ex_en;
    assign hif.if_id_flush   = if_id_flush;
    assign hif.id_ex_bubble  = id_ex_bubble;
    assign hif.ex_mem_bubble = ex_mem_bubble;
    assign hif.mul_start     = mul_start;
    assign hif.busy          = rst_n && (state_q != RUN);
    assign hif.stall_cnt     = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (A: LOAD_LAT=1/CNT_W=16,
// B: LOAD_LAT=2/CNT_W=2) fed identical stimulus.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       id_valid, id_rs_used, id_rt_used, id_is_mul, ex_valid, ex_mem_read;
    logic       ex_branch_taken, mul_ready, mul_done, stat_clr;
    logic [3:0] id_rs, id_rt, ex_wrt_dst;

    hazard_if #(.REG_AW(4), .CNT_W(16)) ia ();
    hazard_if #(.REG_AW(4), .CNT_W(2))  ib ();

    hazard_ctrl #(.REG_AW(4), .LOAD_LAT(1), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .hif(ia));
    hazard_ctrl #(.REG_AW(4), .LOAD_LAT(2), .CNT_W(2))  dut_b (.clk(clk), .rst_n(rst_n), .hif(ib));

    assign ia.id_valid = id_valid;               assign ib.id_valid = id_valid;
    assign ia.id_rs = id_rs;                     assign ib.id_rs = id_rs;
    assign ia.id_rt = id_rt;                     assign ib.id_rt = id_rt;
    assign ia.id_rs_used = id_rs_used;           assign ib.id_rs_used = id_rs_used;
    assign ia.id_rt_used = id_rt_used;           assign ib.id_rt_used = id_rt_used;
    assign ia.id_is_mul = id_is_mul;             assign ib.id_is_mul = id_is_mul;
    assign ia.ex_valid = ex_valid;               assign ib.ex_valid = ex_valid;
    assign ia.ex_mem_read = ex_mem_read;         assign ib.ex_mem_read = ex_mem_read;
    assign ia.ex_wrt_dst = ex_wrt_dst;           assign ib.ex_wrt_dst = ex_wrt_dst;
    assign ia.ex_branch_taken = ex_branch_taken; assign ib.ex_branch_taken = ex_branch_taken;
    assign ia.mul_ready = mul_ready;             assign ib.mul_ready = mul_ready;
    assign ia.mul_done = mul_done;               assign ib.mul_done = mul_done;
    assign ia.stat_clr = stat_clr;               assign ib.stat_clr = stat_clr;

    int n_cmp = 0;
    int n_fail = 0;

    // Output vector order: {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_bubble, ex_mem_bubble, mul_start, busy}
    localparam logic [7:0] O_RUN   = 8'b1110_0000;
    localparam logic [7:0] O_STALL = 8'b0010_1000;
    localparam logic [7:0] O_LDBSY = 8'b0010_1001;
    localparam logic [7:0] O_FLUSH = 8'b1111_1000;
    localparam logic [7:0] O_ISSUE = 8'b1110_0010;
    localparam logic [7:0] O_MULW  = 8'b0000_0101;
    localparam logic [7:0] O_DONE  = 8'b1110_0001;
    localparam logic [7:0] O_RST   = 8'b0000_1000;

    function automatic logic [15:0] outs();
        return {ia.pc_en, ia.if_id_en, ia.id_ex_en, ia.if_id_flush, ia.id_ex_bubble,
                ia.ex_mem_bubble, ia.mul_start, ia.busy,
                ib.pc_en, ib.if_id_en, ib.id_ex_en, ib.if_id_flush, ib.id_ex_bubble,
                ib.ex_mem_bubble, ib.mul_start, ib.busy};
    endfunction

    function automatic logic [17:0] cnts();
        return {ia.stall_cnt, ib.stall_cnt};
    endfunction

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0; id_is_mul = 0;
        ex_valid = 0; ex_mem_read = 0; ex_wrt_dst = 0; ex_branch_taken = 0;
        mul_ready = 0; mul_done = 0; stat_clr = 0;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic clear_stats();
        nxt(); idle(); stat_clr = 1;
        nxt(); stat_clr = 0;
    endtask

    task automatic test_reset();
        idle();
        #2;
        n_cmp++; if (outs() !== {O_RST, O_RST}) begin n_fail++; $display("FAIL reset_outs got %b exp %b", outs(), {O_RST, O_RST}); end
        n_cmp++; if (cnts() !== 18'd0) begin n_fail++; $display("FAIL reset_cnt got %h exp 0", cnts()); end
        @(negedge clk); rst_n = 1;
        nxt(); #2;
        n_cmp++; if (outs() !== {O_RUN, O_RUN}) begin n_fail++; $display("FAIL reset_run got %b exp %b", outs(), {O_RUN, O_RUN}); end
    endtask

    task automatic test_load_use();
        for (int p = 0; p < 2; p++) begin
            clear_stats();
            id_valid = 1; ex_valid = 1; ex_mem_read = 1; ex_wrt_dst = 5;
            if (p == 0) begin id_rs = 5; id_rs_used = 1; id_rt = 3; id_rt_used = 1; end
            else        begin id_rs = 5; id_rs_used = 0; id_rt = 5; id_rt_used = 1; end
            #2;
            n_cmp++; if (outs() !== {O_STALL, O_STALL}) begin n_fail++; $display("FAIL lu%0d_c1 got %b exp %b", p, outs(), {O_STALL, O_STALL}); end
            nxt(); ex_valid = 0; #2;
            n_cmp++; if (outs() !== {O_RUN, O_LDBSY}) begin n_fail++; $display("FAIL lu%0d_c2 got %b exp %b", p, outs(), {O_RUN, O_LDBSY}); end
            n_cmp++; if (cnts() !== {16'd1, 2'd1}) begin n_fail++; $display("FAIL lu%0d_cnt1 got %h exp %h", p, cnts(), {16'd1, 2'd1}); end
            nxt(); idle(); #2;
            n_cmp++; if (outs() !== {O_RUN, O_RUN}) begin n_fail++; $display("FAIL lu%0d_c3 got %b exp %b", p, outs(), {O_RUN, O_RUN}); end
            n_cmp++; if (cnts() !== {16'd1, 2'd2}) begin n_fail++; $display("FAIL lu%0d_cnt2 got %h exp %h", p, cnts(), {16'd1, 2'd2}); end
        end
        // Destination x0 never hazards.
        clear_stats();
        id_valid = 1; ex_valid = 1; ex_mem_read = 1; ex_wrt_dst = 0; id_rs = 0; id_rs_used = 1;
        #2;
        n_cmp++; if (outs() !== {O_RUN, O_RUN}) begin n_fail++; $display("FAIL lu_x0 got %b exp %b", outs(), {O_RUN, O_RUN}); end
        nxt(); idle(); #2;
        n_cmp++; if (cnts() !== 18'd0) begin n_fail++; $display("FAIL lu_x0_cnt got %h exp 0", cnts()); end
    endtask

    task automatic test_branch();
        clear_stats();
        id_valid = 1; ex_valid = 1; ex_mem_read = 1; ex_wrt_dst = 7; id_rs = 7; id_rs_used = 1;
        id_is_mul = 1; mul_ready = 1; ex_branch_taken = 1;
        #2;
        n_cmp++; if (outs() !== {O_FLUSH, O_FLUSH}) begin n_fail++; $display("FAIL branch got %b exp %b", outs(), {O_FLUSH, O_FLUSH}); end
        nxt(); idle(); #2;
        n_cmp++; if (outs() !== {O_RUN, O_RUN}) begin n_fail++; $display("FAIL branch_after got %b exp %b", outs(), {O_RUN, O_RUN}); end
        n_cmp++; if (cnts() !== 18'd0) begin n_fail++; $display("FAIL branch_cnt got %h exp 0", cnts()); end
    endtask

    task automatic test_mul();
        clear_stats();
        id_valid = 1; id_is_mul = 1; mul_ready = 1;
        #2;
        n_cmp++; if (outs() !== {O_ISSUE, O_ISSUE}) begin n_fail++; $display("FAIL mul_issue got %b exp %b", outs(), {O_ISSUE, O_ISSUE}); end
        for (int c = 0; c < 5; c++) begin
            nxt(); id_is_mul = 0; mul_ready = 0; ex_branch_taken = (c == 2); #2;
            n_cmp++; if (outs() !== {O_MULW, O_MULW}) begin n_fail++; $display("FAIL mul_wait%0d got %b exp %b", c, outs(), {O_MULW, O_MULW}); end
        end
        // Done and ready together with another mul in ID: done wins, no issue.
        nxt(); ex_branch_taken = 0; mul_done = 1; mul_ready = 1; id_is_mul = 1; #2;
        n_cmp++; if (outs() !== {O_DONE, O_DONE}) begin n_fail++; $display("FAIL mul_done got %b exp %b", outs(), {O_DONE, O_DONE}); end
        // Done pulse in RUN is ignored.
        nxt(); idle(); mul_done = 1; #2;
        n_cmp++; if (outs() !== {O_RUN, O_RUN}) begin n_fail++; $display("FAIL mul_after got %b exp %b", outs(), {O_RUN, O_RUN}); end
        n_cmp++; if (cnts() !== {16'd5, 2'd3}) begin n_fail++; $display("FAIL mul_cnt_sat got %h exp %h", cnts(), {16'd5, 2'd3}); end
        nxt(); idle(); #2;
        n_cmp++; if (outs() !== {O_RUN, O_RUN}) begin n_fail++; $display("FAIL mul_stray_done got %b exp %b", outs(), {O_RUN, O_RUN}); end
    endtask

    task automatic test_struct();
        clear_stats();
        #2;
        n_cmp++; if (cnts() !== 18'd0) begin n_fail++; $display("FAIL st_clr0 got %h exp 0", cnts()); end
        for (int c = 0; c < 3; c++) begin
            id_valid = 1; id_is_mul = 1; mul_ready = 0; #2;
            n_cmp++; if (outs() !== {O_STALL, O_STALL}) begin n_fail++; $display("FAIL st_stall%0d got %b exp %b", c, outs(), {O_STALL, O_STALL}); end
            nxt();
        end
        mul_ready = 1; #2;
        n_cmp++; if (outs() !== {O_ISSUE, O_ISSUE}) begin n_fail++; $display("FAIL st_issue got %b exp %b", outs(), {O_ISSUE, O_ISSUE}); end
        nxt(); idle(); mul_done = 1; #2;
        n_cmp++; if (outs() !== {O_DONE, O_DONE}) begin n_fail++; $display("FAIL st_done got %b exp %b", outs(), {O_DONE, O_DONE}); end
        // Structural stall in the same cycle as clear: clear wins.
        nxt(); idle(); id_valid = 1; id_is_mul = 1; stat_clr = 1; #2;
        n_cmp++; if (cnts() !== {16'd3, 2'd3}) begin n_fail++; $display("FAIL st_cnt got %h exp %h", cnts(), {16'd3, 2'd3}); end
        nxt(); idle(); #2;
        n_cmp++; if (cnts() !== 18'd0) begin n_fail++; $display("FAIL st_clr got %h exp 0", cnts()); end
    endtask

    task automatic test_reset_mid();
        clear_stats();
        id_valid = 1; id_is_mul = 1; mul_ready = 1;
        for (int c = 0; c < 3; c++) begin nxt(); idle(); end
        #2;
        n_cmp++; if (outs() !== {O_MULW, O_MULW}) begin n_fail++; $display("FAIL rm_wait got %b exp %b", outs(), {O_MULW, O_MULW}); end
        rst_n = 0; #1;
        n_cmp++; if (outs() !== {O_RST, O_RST}) begin n_fail++; $display("FAIL rm_forced got %b exp %b", outs(), {O_RST, O_RST}); end
        n_cmp++; if (cnts() !== 18'd0) begin n_fail++; $display("FAIL rm_cnt got %h exp 0", cnts()); end
        nxt(); rst_n = 1; mul_done = 1; #2;
        n_cmp++; if (outs() !== {O_RUN, O_RUN}) begin n_fail++; $display("FAIL rm_run got %b exp %b", outs(), {O_RUN, O_RUN}); end
        nxt(); idle(); #2;
        n_cmp++; if (outs() !== {O_RUN, O_RUN}) begin n_fail++; $display("FAIL rm_after got %b exp %b", outs(), {O_RUN, O_RUN}); end
        n_cmp++; if (cnts() !== 18'd0) begin n_fail++; $display("FAIL rm_cnt2 got %h exp 0", cnts()); end
    endtask

    // Reference model: remaining forced load-stall cycles, outstanding mul op, stall count.
    int m_ld [2];
    bit m_mul [2];
    int m_cnt [2];
    int m_lat [2] = '{1, 2};
    int m_w [2] = '{16, 2};

    task automatic model_step(input int i, output logic [7:0] eo, output logic [15:0] ec);
        bit lu, pc, ifid, idex, fl, bub, emb, st, bz;
        lu = id_valid && ex_valid && ex_mem_read && (ex_wrt_dst != 0) &&
             ((id_rs_used && id_rs == ex_wrt_dst) || (id_rt_used && id_rt == ex_wrt_dst));
        pc = 1; ifid = 1; idex = 1; fl = 0; bub = 0; emb = 0; st = 0;
        bz = (m_ld[i] > 0) || m_mul[i];
        if (!rst_n) begin
            pc = 0; ifid = 0; idex = 0; bub = 1; bz = 0;
            m_ld[i] = 0; m_mul[i] = 0; m_cnt[i] = 0;
        end else if (m_ld[i] > 0) begin
            pc = 0; ifid = 0; bub = 1; m_ld[i]--;
        end else if (m_mul[i]) begin
            if (mul_done) m_mul[i] = 0;
            else begin pc = 0; ifid = 0; idex = 0; emb = 1; end
        end else if (ex_branch_taken) begin
            fl = 1; bub = 1;
        end else if (lu) begin
            pc = 0; ifid = 0; bub = 1; m_ld[i] = m_lat[i] - 1;
        end else if (id_valid && id_is_mul && mul_ready) begin
            st = 1; m_mul[i] = 1;
        end else if (id_valid && id_is_mul) begin
            pc = 0; ifid = 0; bub = 1;
        end
        eo = {pc, ifid, idex, fl, bub, emb, st, bz};
        ec = 16'(m_cnt[i]);
        if (rst_n) begin
            if (stat_clr) m_cnt[i] = 0;
            else if (!pc && m_cnt[i] < (1 << m_w[i]) - 1) m_cnt[i]++;
        end
    endtask

    task automatic test_random();
        logic [7:0]  ea, eb;
        logic [15:0] ca, cb;
        clear_stats();
        for (int i = 0; i < 2; i++) begin m_ld[i] = 0; m_mul[i] = 0; m_cnt[i] = 0; end
        for (int c = 0; c < 800; c++) begin
            rst_n           = ($urandom_range(0, 99) != 0);
            id_valid        = ($urandom_range(0, 9) < 8);
            id_rs           = 4'($urandom_range(0, 3));
            id_rt           = 4'($urandom_range(0, 3));
            id_rs_used      = 1'($urandom_range(0, 1));
            id_rt_used      = 1'($urandom_range(0, 1));
            id_is_mul       = ($urandom_range(0, 4) == 0);
            ex_valid        = ($urandom_range(0, 9) < 7);
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_wrt_dst      = 4'($urandom_range(0, 3));
            ex_branch_taken = ($urandom_range(0, 9) == 0);
            mul_ready       = ($urandom_range(0, 9) < 7);
            mul_done        = ($urandom_range(0, 3) == 0);
            stat_clr        = ($urandom_range(0, 31) == 0);
            #2;
            model_step(0, ea, ca);
            model_step(1, eb, cb);
            n_cmp++; if (outs() !== {ea, eb}) begin n_fail++; $display("FAIL rand_outs cyc %0d got %b exp %b", c, outs(), {ea, eb}); end
            n_cmp++; if (cnts() !== {ca, cb[1:0]}) begin n_fail++; $display("FAIL rand_cnt cyc %0d got %h exp %h", c, cnts(), {ca, cb[1:0]}); end
            nxt();
        end
        rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mul();
        test_struct();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
